// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply, restoring divide, MTHI/MTLO writes.
// Optional MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU; divide stays iterative.
module muldiv_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        cancel,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nx;
   logic [4:0]  iter;
   logic [63:0] acc;
   logic [31:0] opnd_q;
   logic [31:0] src1_q;
   logic        is_div_q, neg_lo_q, neg_hi_q, div_zero_q;

   logic        accept, fast_go, last;
   logic        sgn_op, s1_neg, s2_neg;
   logic [31:0] a1_mag, a2_mag;
   logic [32:0] mul_sum, div_rem, div_diff;
   logic [63:0] mul_next, div_next, step_next, prod;
   logic [31:0] res_hi, res_lo, quot, rem;
   logic [63:0] fast_prod;

   assign accept = start && !cancel && (state == IDLE || state == DONE);
   assign last   = (iter == 5'd31);

`ifdef MULDIV_FAST_MULT_EN
   logic [63:0] ext1, ext2;
   assign ext1      = {{32{!op[0] && src1[31]}}, src1};
   assign ext2      = {{32{!op[0] && src2[31]}}, src2};
   assign fast_prod = ext1 * ext2;
   assign fast_go   = accept && !op[1];
`else
   assign fast_prod = 64'd0;
   assign fast_go   = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (accept) state_nx = fast_go ? DONE : RUN;
         RUN: begin
            busy = 1'b1;
            if (cancel)    state_nx = IDLE;
            else if (last) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) state_nx = fast_go ? DONE : RUN;
            else        state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Operand magnitudes and sign bookkeeping captured at the accepting edge.
   always_comb begin
      sgn_op = !op[0];
      s1_neg = sgn_op && src1[31];
      s2_neg = sgn_op && src2[31];
      a1_mag = s1_neg ? -src1 : src1;
      a2_mag = s2_neg ? -src2 : src2;
   end

   // One iteration: multiply adds the multiplicand under the LSB and shifts right;
   // divide shifts the remainder left and keeps the trial subtraction if non-negative.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
      mul_next  = {mul_sum, acc[31:1]};
      div_rem   = {acc[63:32], acc[31]};
      div_diff  = div_rem - {1'b0, opnd_q};
      div_next  = div_diff[32] ? {div_rem[31:0], acc[30:0], 1'b0}
                               : {div_diff[31:0], acc[30:0], 1'b1};
      step_next = is_div_q ? div_next : mul_next;
   end

   always_comb begin
      prod = neg_lo_q ? -step_next : step_next;
      quot = step_next[31:0];
      rem  = step_next[63:32];
      if (is_div_q) begin
         res_lo = neg_lo_q ? -quot : quot;
         res_hi = neg_hi_q ? -rem : rem;
         if (div_zero_q) begin
            res_lo = 32'hFFFF_FFFF;
            res_hi = src1_q;
         end
      end else begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iter       <= 5'd0;
         acc        <= 64'd0;
         opnd_q     <= 32'd0;
         src1_q     <= 32'd0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (accept) begin
         iter       <= 5'd0;
         is_div_q   <= op[1];
         src1_q     <= src1;
         neg_lo_q   <= s1_neg ^ s2_neg;
         neg_hi_q   <= op[1] && s1_neg;
         div_zero_q <= op[1] && (src2 == 32'd0);
         opnd_q     <= op[1] ? a2_mag : a1_mag;
         acc        <= {32'd0, op[1] ? a1_mag : a2_mag};
      end else if (state == RUN && !cancel) begin
         iter <= iter + 5'd1;
         acc  <= step_next;
      end
   end

   // HI/LO: the operation result on completion; MTHI/MTLO only outside RUN.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (fast_go) begin
         hi <= fast_prod[63:32];
         lo <= fast_prod[31:0];
      end else if (state == RUN) begin
         if (!cancel && last) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end else begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

endmodule
